// File: rtl/sc_keypulse_pkg.sv
// Shared types and helpers for the key-pulse conditioning stage.
package sc_keypulse_pkg;

   // FSM state encodings for the key conditioner.
   typedef enum logic [1:0] {
      ST_IDLE        = 2'b00,
      ST_DEB_PRESS   = 2'b01,
      ST_HELD        = 2'b10,
      ST_DEB_RELEASE = 2'b11
   } kp_state_e;

   // Number of bits needed to hold the values 0 .. value-1.
   function automatic int unsigned kp_clog2(input int unsigned value);
      int unsigned v;
      int unsigned w;
      w = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v != 0) begin
         w++;
         v = v >> 1;
      end
      return w;
   endfunction

   // Timer width sized for the largest of the three cycle counts, never below 1 bit.
   function automatic int unsigned kp_timer_width(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
      int unsigned m;
      int unsigned w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      w = kp_clog2(m);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/sc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input (buttons, switches).
module sc_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; the first stage may go metastable, the second settles it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sc_key_pulse.sv
// Debounces an active-low push-button and emits a one-cycle active-low step
// request per accepted press, with optional auto-repeat while held.
module sc_key_pulse
   import sc_keypulse_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 10000000,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic SC_KEYPULSE_CLOCK_50,
   input  logic SC_KEYPULSE_RESET_InLow,
   input  logic SC_KEYPULSE_key_InLow,
   output logic SC_KEYPULSE_pulse_OutLow,
   output logic SC_KEYPULSE_level_OutLow
);

   localparam int unsigned TW = kp_timer_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

   localparam logic [TW-1:0] DEB_LOAD  = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_LOAD  = TW'(REPEAT_CYCLES - 1);

   logic          key_s;
   kp_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pulse_q, pulse_d;
   logic          level_q, level_d;
   logic          timer_zero;

   sc_sync2 #(
      .RESET_VAL (1'b1)
   ) u_key_sync (
      .clk_i  (SC_KEYPULSE_CLOCK_50),
      .rst_ni (SC_KEYPULSE_RESET_InLow),
      .d_i    (SC_KEYPULSE_key_InLow),
      .q_o    (key_s)
   );

   assign timer_zero = (timer_q == '0);

   // Next-state, timer reload and output decisions.
   always_comb begin
      state_d = state_q;
      timer_d = timer_zero ? timer_q : timer_q - TW'(1);
      pulse_d = 1'b1;
      level_d = level_q;

      case (state_q)
         ST_IDLE: begin
            level_d = 1'b1;
            if (!key_s) begin
               state_d = ST_DEB_PRESS;
               timer_d = DEB_LOAD;
            end
         end

         ST_DEB_PRESS: begin
            if (key_s) begin
               state_d = ST_IDLE;
            end else if (timer_zero) begin
               state_d = ST_HELD;
               timer_d = HOLD_LOAD;
               pulse_d = 1'b0;
               level_d = 1'b0;
            end
         end

         ST_HELD: begin
            // Release is tested first so a coinciding repeat tick is dropped.
            if (key_s) begin
               state_d = ST_DEB_RELEASE;
               timer_d = DEB_LOAD;
            end else if (REPEAT_EN && timer_zero) begin
               timer_d = REP_LOAD;
               pulse_d = 1'b0;
            end
         end

         ST_DEB_RELEASE: begin
            if (!key_s) begin
               state_d = ST_HELD;
               timer_d = HOLD_LOAD;
            end else if (timer_zero) begin
               state_d = ST_IDLE;
               level_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // State, shared timer and registered outputs.
   always_ff @(posedge SC_KEYPULSE_CLOCK_50 or negedge SC_KEYPULSE_RESET_InLow) begin
      if (!SC_KEYPULSE_RESET_InLow) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         pulse_q <= 1'b1;
         level_q <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

   assign SC_KEYPULSE_pulse_OutLow = pulse_q;
   assign SC_KEYPULSE_level_OutLow = level_q;

endmodule

// File: tb/tb_sc_key_pulse.sv
// Scoreboard bench for sc_key_pulse: two instances (auto-repeat on/off) share
// key and reset; expected pulse and level-change cycles are queued by the
// stimulus and consumed by a monitor running on the falling clock edge.
module tb_sc_key_pulse;
   import sc_keypulse_pkg::*;

   typedef struct {
      int   cyc;
      logic val;
   } lvl_exp_t;

   logic clk;
   logic rst_n;
   logic key;
   logic pulse_rep, pulse_norep, level_rep, level_norep;
   logic [1:0] pulse_w, level_w;
   logic [1:0] prev_pulse, prev_level;

   int cyc;
   int n_checks;
   int n_fail;
   int       pq[2][$];
   lvl_exp_t lq[2][$];
   string    nm[2];

   assign pulse_w = {pulse_norep, pulse_rep};
   assign level_w = {level_norep, level_rep};

   sc_key_pulse #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (5),
      .REPEAT_EN       (1'b1)
   ) u_rep (
      .SC_KEYPULSE_CLOCK_50     (clk),
      .SC_KEYPULSE_RESET_InLow  (rst_n),
      .SC_KEYPULSE_key_InLow    (key),
      .SC_KEYPULSE_pulse_OutLow (pulse_rep),
      .SC_KEYPULSE_level_OutLow (level_rep)
   );

   sc_key_pulse #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (5),
      .REPEAT_EN       (1'b0)
   ) u_norep (
      .SC_KEYPULSE_CLOCK_50     (clk),
      .SC_KEYPULSE_RESET_InLow  (rst_n),
      .SC_KEYPULSE_key_InLow    (key),
      .SC_KEYPULSE_pulse_OutLow (pulse_norep),
      .SC_KEYPULSE_level_OutLow (level_norep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle k is the interval following rising edge k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   // Change key at a falling edge; first = rising edge that first samples it.
   task automatic key_edge(input logic v, output int first);
      @(negedge clk);
      key   = v;
      first = cyc + 1;
   endtask

   task automatic hold(input int n);
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic exp_pulse(input int idx, input int c);
      pq[idx].push_back(c);
   endtask

   task automatic exp_level(input int c, input logic v);
      lvl_exp_t e;
      e.cyc = c;
      e.val = v;
      lq[0].push_back(e);
      lq[1].push_back(e);
   endtask

   initial begin
      int n;
      int g;
      cyc        = 0;
      n_checks   = 0;
      n_fail     = 0;
      nm[0]      = "rep";
      nm[1]      = "norep";
      prev_pulse = 2'b11;
      prev_level = 2'b11;
      rst_n      = 1'b0;
      key        = 1'b0;

      fork
         forever begin : monitor
            int       e;
            lvl_exp_t le;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               if (rst_n && pulse_w[i] == 1'b0) begin
                  n_checks++;
                  if (pq[i].size() == 0) begin
                     n_fail++;
                     $display("FAIL pulse_%s: low in cycle %0d, required no pulse", nm[i], cyc);
                  end else begin
                     e = pq[i].pop_front();
                     if (e != cyc) begin
                        n_fail++;
                        $display("FAIL pulse_%s: low in cycle %0d, required cycle %0d", nm[i], cyc, e);
                     end
                  end
                  n_checks++;
                  if (prev_pulse[i] == 1'b0) begin
                     n_fail++;
                     $display("FAIL pulse_width_%s: low for 2+ cycles at cycle %0d, required 1", nm[i], cyc);
                  end
               end
               if (rst_n && level_w[i] != prev_level[i]) begin
                  n_checks++;
                  if (lq[i].size() == 0) begin
                     n_fail++;
                     $display("FAIL level_%s: changed to %b in cycle %0d, required no change", nm[i], level_w[i], cyc);
                  end else begin
                     le = lq[i].pop_front();
                     if (le.cyc != cyc || le.val != level_w[i]) begin
                        n_fail++;
                        $display("FAIL level_%s: %b in cycle %0d, required %b in cycle %0d",
                                 nm[i], level_w[i], cyc, le.val, le.cyc);
                     end
                  end
               end
               prev_pulse[i] = pulse_w[i];
               prev_level[i] = level_w[i];
            end
         end
      join_none

      // Reset with key already pressed: outputs idle, then a normal debounced press.
      repeat (3) @(negedge clk);
      check("reset_pulse_rep",   pulse_rep,   1'b1);
      check("reset_level_rep",   level_rep,   1'b1);
      check("reset_pulse_norep", pulse_norep, 1'b1);
      check("reset_level_norep", level_norep, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      n = cyc + 1;
      exp_pulse(0, n + 6);
      exp_pulse(1, n + 6);
      exp_level(n + 6, 1'b0);
      exp_level(n + 14, 1'b1);
      repeat (7) @(negedge clk);
      key_edge(1'b1, g); hold(10);

      // Clean press held 8 cycles.
      key_edge(1'b0, n);
      exp_pulse(0, n + 6);
      exp_pulse(1, n + 6);
      exp_level(n + 6, 1'b0);
      exp_level(n + 14, 1'b1);
      hold(8);
      key_edge(1'b1, g); hold(10);

      // Bounce, then a too-short press: nothing expected.
      key_edge(1'b0, g); hold(1);
      key_edge(1'b1, g); hold(1);
      key_edge(1'b0, g); hold(1);
      key_edge(1'b1, g); hold(8);
      key_edge(1'b0, g); hold(3);
      key_edge(1'b1, g); hold(10);

      // Auto-repeat: held 40 cycles.
      key_edge(1'b0, n);
      exp_pulse(0, n + 6);
      exp_pulse(0, n + 16);
      exp_pulse(0, n + 21);
      exp_pulse(0, n + 26);
      exp_pulse(0, n + 31);
      exp_pulse(0, n + 36);
      exp_pulse(0, n + 41);
      exp_pulse(1, n + 6);
      exp_level(n + 6, 1'b0);
      exp_level(n + 46, 1'b1);
      hold(40);
      key_edge(1'b1, g); hold(10);

      // Release glitch: 2 cycles high at edges n+12..n+13 coincides with the
      // would-be repeat at n+16; return to HELD at n+16 restarts the hold delay.
      key_edge(1'b0, n);
      exp_pulse(0, n + 6);
      exp_pulse(0, n + 26);
      exp_pulse(0, n + 31);
      exp_pulse(1, n + 6);
      exp_level(n + 6, 1'b0);
      exp_level(n + 40, 1'b1);
      hold(12);
      key_edge(1'b1, g); hold(2);
      key_edge(1'b0, g); hold(20);
      key_edge(1'b1, g); hold(10);

      // Reset asserted during the press pulse cycle cuts it at once.
      key_edge(1'b0, n);
      repeat (7) @(posedge clk);
      #1;
      check("pre_reset_pulse_rep",   pulse_rep,   1'b0);
      check("pre_reset_pulse_norep", pulse_norep, 1'b0);
      check("pre_reset_level_rep",   level_rep,   1'b0);
      rst_n = 1'b0;
      #1;
      check("cut_pulse_rep",   pulse_rep,   1'b1);
      check("cut_pulse_norep", pulse_norep, 1'b1);
      check("cut_level_rep",   level_rep,   1'b1);
      check("cut_level_norep", level_norep, 1'b1);
      check("cut_state_rep",   u_rep.state_q == ST_IDLE,   1'b1);
      check("cut_state_norep", u_norep.state_q == ST_IDLE, 1'b1);
      key = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Every queued expectation must have been consumed.
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (pq[i].size() != 0) begin
            n_fail++;
            $display("FAIL pulse_left_%s: %0d pulses missing, required 0", nm[i], pq[i].size());
         end
         n_checks++;
         if (lq[i].size() != 0) begin
            n_fail++;
            $display("FAIL level_left_%s: %0d level changes missing, required 0", nm[i], lq[i].size());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
